// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

  // bit 0 clear selects the signed variant, bit 1 set selects divide
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Controller-facing bundle of the multiply/divide unit: operation request,
// MTHI/MTLO writes and the HI/LO/busy/done results.
interface mdu_iter_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a_in, b_in, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a_in, b_in, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_dvs});
  // when the divisor fits, the difference is below 2^WIDTH, so the low bits suffice
  assign o_rem   = o_q ? (w_shift[WIDTH-1:0] - i_dvs) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair;
// works on operand magnitudes and applies sign fix-up in FIN.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one multiply or divide iteration per cycle, WIDTH cycles
// FIN   | sign fix-up, HI/LO written at the next edge
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         r_state, w_state_nxt;
  mdu_op_e            r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt, w_prod;
  logic [WIDTH-1:0]   r_dvs, r_hi, r_lo, w_res_hi, w_res_lo;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_rem;
  logic [WIDTH:0]     w_sum;
  logic               r_neg_q, r_neg_r, r_dz, r_busy, r_done;
  logic               w_load, w_iter, w_fin, w_mt, w_signed, w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CW'(WIDTH-1)) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state == IDLE) && bus.start;
    w_mt   = (r_state == IDLE) && !bus.start;
    w_iter = (r_state == CALC);
    w_fin  = (r_state == FIN);
  end

  assign w_signed = op_is_signed(bus.op);
  assign w_a_mag  = (w_signed && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign w_b_mag  = (w_signed && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;

  // multiply: upper half accumulates, multiplier drains out of the low half
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 {1'b0, (r_acc[0] ? r_dvs : {WIDTH{1'b0}})};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit (r_acc[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem),
    .o_q   (w_q)
  );

  assign w_acc_nxt = op_is_div(r_op) ? {w_rem, r_acc[WIDTH-2:0], w_q}
                                     : {w_sum, r_acc[WIDTH-1:1]};

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (op_is_div(r_op)) begin
      w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_dz ? {WIDTH{1'b1}}
               : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= MDU_MULT;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_op    <= mdu_op_e'(bus.op);
        r_cnt   <= '0;
        r_neg_q <= w_signed && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
        r_neg_r <= w_signed && bus.a_in[WIDTH-1];
        r_dz    <= (bus.b_in == '0);
        if (op_is_div(bus.op)) begin
          r_acc <= {{WIDTH{1'b0}}, w_a_mag};
          r_dvs <= w_b_mag;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_b_mag};
          r_dvs <= w_a_mag;
        end
      end else if (w_iter) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_fin) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end

      r_busy <= (w_state_nxt != IDLE);
      r_done <= w_fin;
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: MT writes, signed/unsigned multiply and divide,
// divide by zero, overflow, ignored requests while busy and mid-op reset.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check HI/LO hold during busy, busy length, done pulse and result.
  task automatic run_op(input string tag, input logic [1:0] op_v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit wr_at_start, input bit disturb);
    int busy_n;
    int extra_done;
    bit got;
    bus.op    = op_v;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    bus.lo_we = wr_at_start;
    bus.wdata = 32'h0BAD_0BAD;
    step();
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    chk({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_hi_hold"}, bus.hi, prev_hi);
    chk({tag, "_lo_hold"}, bus.lo, prev_lo);
    busy_n = 0;
    got    = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
      else begin
        bus.start = disturb && (c == 5);
        bus.hi_we = disturb && (c == 5);
        bus.wdata = 32'hDEAD_BEEF;
        step();
      end
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_n, 32'd33);
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    step();
    chk({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
    if (disturb) begin
      extra_done = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus.done || bus.busy) extra_done++;
        step();
      end
      chk({tag, "_no_second_op"}, extra_done, 32'd0);
      chk({tag, "_hi_after"}, bus.hi, exp_hi);
    end
  endtask

  initial begin
    int stray;
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    step();
    bus.lo_we = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h0000_1234);
    chk("mtlo_hi", bus.hi, 32'h0);

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    step();
    bus.lo_we = 1'b0;
    bus.wdata = 32'h0000_0055;
    chk("mtboth_hi", bus.hi, 32'hA5A5_A5A5);
    chk("mtboth_lo", bus.lo, 32'hA5A5_A5A5);
    step();
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h0000_0055);
    chk("mthi_lo", bus.lo, 32'hA5A5_A5A5);

    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5,
           32'h0000_0055, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("divu_dz", MDU_DIVU, 32'd100, 32'd0,
           32'h0000_0000, 32'h8000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("div_dz_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd0,
           32'h0000_0064, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);

    bus.op    = MDU_DIVU;
    bus.a_in  = 32'd1000;
    bus.b_in  = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_hi", bus.hi, 32'h0);
    chk("rstmid_lo", bus.lo, 32'h0);
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid_done", {31'd0, bus.done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.done || bus.busy) stray++;
    end
    chk("rstmid_no_done", stray, 32'd0);
    chk("rstmid_lo_stay", bus.lo, 32'h0);

    run_op("divu_after_rst", MDU_DIVU, 32'd1000, 32'd7,
           32'h0, 32'h0, 32'd6, 32'd142, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit for the multi-cycle MIPS32 datapath. It sits directly downstream of the A/B operand registers. It consumes the latched rs value (a_in) and the latched rt value (b_in, the raw GPR busB copy, never the immediate-muxed operand). It executes MULT/MULTU/DIV/DIVU over 32 iterations and holds the architectural HI/LO registers. The main controller stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI/LO and all datapath registers are WIDTH bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  single-cycle request to begin the operation in op
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_in  input  WIDTH  operand A (rs); dividend for divides
b_in  input  WIDTH  operand B (rt); divisor for divides
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  data for MTHI/MTLO
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo take a new result

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset asserted mid-operation aborts it immediately. No result is written and hi/lo go to 0.
- States:
  - IDLE: start=1 at edge E0 latches op, the operand magnitudes and the result-sign flags, then enters CALC with count=0.
  - CALC: one iteration per cycle. count increments each edge. The edge at which count reaches WIDTH-1 moves to FIN.
  - FIN: sign fix-up and write of hi/lo at the next edge, then back to IDLE.
- Timing: busy=1 from the cycle after E0 until hi/lo update, i.e. WIDTH+1 cycles. hi/lo change and done=1 in the cycle after the FIN edge (E0+WIDTH+2 edges), with busy=0 in that same cycle. done lasts exactly one cycle. done and busy are registered outputs.
- Signed ops (MULT, DIV): operands converted to magnitude at E0.
  - MULT: product negated if signs differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
- Multiply: shift-add on a 2*WIDTH accumulator. Result is hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring, one quotient bit per cycle. Result is lo = quotient, hi = remainder.
- Divide by zero (b_in==0 at E0): hi = a_in as latched, lo = all ones. The iteration still takes the full latency.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0. Falls out of the magnitude method and needs no special case.
- start while busy: ignored, current operation unaffected.
- hi_we/lo_we:
  - Honoured only when busy=0.
  - hi/lo take wdata at the next edge.
  - hi_we and lo_we together both take wdata.
  - Ignored while busy; the controller must stall instead.
- start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
- Operands are sampled only at E0. a_in/b_in may change freely afterwards.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU
  - state enum IDLE/CALC/FIN
  - WIDTH default constant
- One natural sub-module, mdu_div_step: combinational one-bit restoring step. Inputs are partial remainder, dividend bit and divisor. Outputs are the next remainder and the quotient bit. It is instantiated once in mdu_iter.
- Multiply add-shift stays inline.

Test Plan:
- Reset then idle: rst_n=0 -> hi=0, lo=0, busy=0, done=0; MTLO 0x1234 with lo_we=1 -> lo=0x00001234 next cycle, hi unchanged.
- MULT a=0xFFFFFFFD (-3), b=5 -> after WIDTH+2 edges, done pulse 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; change a_in/b_in during CALC -> result unchanged.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF; second start and hi_we pulsed during busy -> both ignored, single done pulse.
- rst_n pulsed low 10 cycles into a DIVU 1000/7 -> immediate IDLE, hi=lo=0, no done; new DIVU 1000/7 afterwards -> lo=142, hi=6.
